// File: rtl/nrisc_pkg.sv
// Shared encodings for the nRISC multicycle control path.
// Opcodes, FSM state codes, ALU-control op codes and datapath mux selects.
// Pure declarations; no logic.
package nrisc_pkg;

  typedef enum logic [2:0] {
    OP_ARIT = 3'b000,
    OP_LOGI = 3'b001,
    OP_LW   = 3'b010,
    OP_SW   = 3'b011,
    OP_BEQ  = 3'b100,
    OP_JMP  = 3'b101,
    OP_ADDI = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    INICIO     = 3'd0,
    BUSCA      = 3'd1,
    DECODIFICA = 3'd2,
    EXECUTA    = 3'd3,
    MEMORIA    = 3'd4,
    ESCRITA    = 3'd5,
    PARADO     = 3'd6,
    ERRO       = 3'd7
  } estado_t;

  // ula_op codes seen by the ALU-control decoder
  localparam logic [1:0] ULAOP_ARIT = 2'b00;  // ADD/SUB chosen by funct
  localparam logic [1:0] ULAOP_LOGI = 2'b01;  // SLT/NOT chosen by funct
  localparam logic [1:0] ULAOP_ADD  = 2'b10;  // plain add (PC+1, addresses)
  localparam logic [1:0] ULAOP_ADDI = 2'b11;  // add immediate

  // ula_src_b mux
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_UM  = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  // pc_source mux
  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ULAREG = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/controle_multiciclo_contador_espera.sv
// Memory wait-cycle counter: counts cycles spent waiting on mem_ready.
// limite is combinational from the count; it rises on the MAX-th waiting cycle.
// No backpressure; clear has priority over inc.
module contador_espera #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic limite
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // count waited cycles; cleared whenever the FSM is not stalled on memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds waits already completed, so the current wait is the last allowed one
  assign limite = (cnt == W'(MAX - 1));

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the nRISC core (fetch/decode/execute/memory/writeback).
// Outputs are combinational from the registered state (ir_write/pc_write also follow mem_ready).
// Memory stalls hold mem_req until mem_ready; MAX_ESPERA idle cycles trap into ERRO.
module controle_multiciclo
  import nrisc_pkg::*;
#(
  parameter int MAX_ESPERA = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       ula_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic [1:0] ula_op,
  output logic       ula_funct,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [2:0] estado,
  output logic       erro
);

  estado_t estado_r, estado_nxt;
  opcode_t opcode;
  logic    em_espera;
  logic    limite;

  assign opcode    = opcode_t'(instr[7:5]);
  assign estado    = estado_r;
  assign em_espera = (estado_r == BUSCA) || (estado_r == MEMORIA);

  // the zero flag is gated with pc_write_cond in the datapath; the immediate bits feed the ALU
  logic unused_ok;
  assign unused_ok = ^{ula_zero, instr[4:1]};

  contador_espera #(.MAX(MAX_ESPERA)) u_espera (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!em_espera || mem_ready),
    .inc    (em_espera && !mem_ready),
    .limite (limite)
  );

  // state register; async reset forces INICIO so every output drops immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= INICIO;
    end else begin
      estado_r <= estado_nxt;
    end
  end

  // next-state and datapath strobes for the current state
  always_comb begin
    estado_nxt    = estado_r;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ULA;
    ula_src_a     = 1'b0;
    ula_src_b     = SRCB_REG;
    ula_op        = ULAOP_ARIT;
    ula_funct     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    erro          = 1'b0;

    case (estado_r)
      INICIO: estado_nxt = BUSCA;

      BUSCA: begin
        // fetch while the ALU computes PC+1; IR and PC latch only when data arrives
        mem_req   = 1'b1;
        ula_src_b = SRCB_UM;
        ula_op    = ULAOP_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)   estado_nxt = DECODIFICA;
        else if (limite) estado_nxt = ERRO;
      end

      DECODIFICA: begin
        // speculatively compute the branch target into the ALU register
        ula_src_b  = SRCB_IMM;
        ula_op     = ULAOP_ADD;
        estado_nxt = (opcode == OP_HALT) ? PARADO : EXECUTA;
      end

      EXECUTA: begin
        case (opcode)
          OP_ARIT: begin
            ula_src_a  = 1'b1;
            ula_op     = ULAOP_ARIT;
            ula_funct  = instr[0];
            estado_nxt = ESCRITA;
          end
          OP_LOGI: begin
            ula_src_a  = 1'b1;
            ula_op     = ULAOP_LOGI;
            ula_funct  = instr[0];
            estado_nxt = ESCRITA;
          end
          OP_LW, OP_SW: begin
            ula_src_a  = 1'b1;
            ula_src_b  = SRCB_IMM;
            ula_op     = ULAOP_ADD;
            estado_nxt = MEMORIA;
          end
          OP_ADDI: begin
            ula_src_a  = 1'b1;
            ula_src_b  = SRCB_IMM;
            ula_op     = ULAOP_ADDI;
            estado_nxt = ESCRITA;
          end
          OP_BEQ: begin
            // SUB sets ula_zero; the datapath qualifies pc_write_cond with it
            ula_src_a     = 1'b1;
            ula_op        = ULAOP_ARIT;
            ula_funct     = 1'b1;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ULAREG;
            estado_nxt    = BUSCA;
          end
          OP_JMP: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            estado_nxt = BUSCA;
          end
          OP_HALT: estado_nxt = PARADO;
        endcase
      end

      MEMORIA: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready)   estado_nxt = (opcode == OP_LW) ? ESCRITA : BUSCA;
        else if (limite) estado_nxt = ERRO;
      end

      ESCRITA: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LW);
        estado_nxt = BUSCA;
      end

      PARADO: estado_nxt = PARADO;

      ERRO: begin
        erro       = 1'b1;
        estado_nxt = ERRO;
      end
    endcase
  end

endmodule
